// File: rtl/pmp_mmio_ctrl.sv
// MMIO front end for a bank of pattern-matching modules: staging buffer, command FIFO,
// per-module dispatch with ready/accept handshake, sticky PATT and STATUS flags.
module pmp_mmio_ctrl #(
  parameter int          NUM_MODULES = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               daddr,
  input  logic [31:0]               dwdata,
  input  logic [3:0]                dwe,
  output logic [31:0]               drdata,
  output logic [64*NUM_MODULES-1:0] pmp_data,
  output logic [16*NUM_MODULES-1:0] pmp_control,
  output logic [NUM_MODULES-1:0]    data_ready,
  input  logic [NUM_MODULES-1:0]    data_accepted,
  input  logic [NUM_MODULES-1:0]    pattern_accepted
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 1 + 16 + 5 + 64;

  logic [29:0] word, base_word;
  logic        sel_lo, sel_hi, sel_cmd, sel_busy, sel_patt, sel_status;
  logic        wr;
  logic        unused_addr_lsb;

  assign word      = daddr[31:2];
  assign base_word = BASE_ADDR[31:2];
  assign unused_addr_lsb = ^daddr[1:0];

  assign sel_lo     = (word == base_word);
  assign sel_hi     = (word == base_word + 30'd1);
  assign sel_cmd    = (word == base_word + 30'd2);
  assign sel_busy   = (word == base_word + 30'd3);
  assign sel_patt   = (word == base_word + 30'd4);
  assign sel_status = (word == base_word + 30'd5);
  assign wr         = |dwe;

  logic [63:0]            stage;
  logic [EW-1:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   full, empty;
  logic                   cmd_wr, push, pop, ovf_set;
  logic [NUM_MODULES-1:0] patt, patt_clr, tgt;
  logic                   ovf, idx_err;
  logic                   ovf_clr, idx_clr;

  logic [EW-1:0] head;
  logic          h_bcast, h_nop, idx_bad;
  logic [15:0]   h_ctl;
  logic [4:0]    h_idx;
  logic [63:0]   h_data;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Fullness is judged before this edge's pop, so a CMD into a full FIFO is lost
  // even if the head leaves in the same cycle.
  assign cmd_wr  = sel_cmd && (dwe == 4'hF);
  assign push    = cmd_wr && !full;
  assign ovf_set = cmd_wr && full;

  assign head    = fifo_mem[rd_ptr];
  assign h_bcast = head[85];
  assign h_ctl   = head[84:69];
  assign h_idx   = head[68:64];
  assign h_data  = head[63:0];
  assign h_nop   = (h_ctl[15:14] == 2'b00);
  assign idx_bad = !h_bcast && ({27'b0, h_idx} >= 32'(NUM_MODULES));

  always_comb begin
    tgt = '0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      tgt[i] = h_bcast || (h_idx == 5'(i));
    end
  end

  // An out-of-range index has no targets, so it pops immediately.
  assign pop = !empty && ((tgt & data_ready) == '0);

  assign patt_clr = (sel_patt && wr) ? dwdata[NUM_MODULES-1:0] : '0;
  assign ovf_clr  = sel_status && wr && dwdata[2];
  assign idx_clr  = sel_status && wr && dwdata[3];

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr] <= {dwdata[31], dwdata[30:15], dwdata[4:0], stage};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pmp_data    <= '0;
      pmp_control <= '0;
      data_ready  <= '0;
      patt        <= '0;
      ovf         <= 1'b0;
      idx_err     <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (sel_lo && dwe[b]) stage[8*b +: 8]      <= dwdata[8*b +: 8];
        if (sel_hi && dwe[b]) stage[32+8*b +: 8]   <= dwdata[8*b +: 8];
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      for (int i = 0; i < NUM_MODULES; i++) begin
        if (pop && tgt[i]) begin
          pmp_data[64*i +: 64]    <= h_data;
          pmp_control[16*i +: 16] <= h_ctl;
          data_ready[i]           <= !h_nop;
        end else if (data_accepted[i]) begin
          data_ready[i] <= 1'b0;
        end
      end

      patt    <= (patt & ~patt_clr) | pattern_accepted;
      ovf     <= ovf_set | (ovf & !ovf_clr);
      idx_err <= (pop && idx_bad) | (idx_err & !idx_clr);
    end
  end

  always_comb begin
    drdata = '0;
    if (!wr) begin
      if (sel_busy) begin
        drdata[NUM_MODULES-1:0] = data_ready;
      end else if (sel_patt) begin
        drdata[NUM_MODULES-1:0] = patt;
      end else if (sel_status) begin
        drdata[8 +: CW] = count;
        drdata[3]       = idx_err;
        drdata[2]       = ovf;
        drdata[1]       = full;
        drdata[0]       = empty;
      end
    end
  end

endmodule

// File: tb/tb_pmp_mmio_ctrl.sv
// Bench for pmp_mmio_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based transaction model of the register/FIFO behaviour.
module tb_pmp_mmio_ctrl;

  localparam int          NM    = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic                 clk;
  logic                 reset;
  logic [31:0]          daddr, dwdata, drdata;
  logic [3:0]           dwe;
  logic [64*NM-1:0]     pmp_data;
  logic [16*NM-1:0]     pmp_control;
  logic [NM-1:0]        data_ready, data_accepted, pattern_accepted;

  pmp_mmio_ctrl #(.NUM_MODULES(NM), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .pmp_data(pmp_data), .pmp_control(pmp_control),
    .data_ready(data_ready), .data_accepted(data_accepted),
    .pattern_accepted(pattern_accepted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bc;
    logic [15:0] ctl;
    logic [4:0]  idx;
    logic [63:0] dat;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_stage;
  logic [63:0] m_data [NM];
  logic [15:0] m_ctl  [NM];
  logic [3:0]  m_rdy, m_patt;
  logic        m_ovf, m_idx;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [3:0] be);
    logic [29:0] off;
    off = a[31:2] - BASE[31:2];
    if (be != 4'h0) return 32'h0;
    case (off)
      30'd3: return {28'b0, m_rdy};
      30'd4: return {28'b0, m_patt};
      30'd5: return {16'b0, 8'(q.size()), 4'b0, m_idx, m_ovf,
                     q.size() == DEPTH, q.size() == 0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [29:0] off;
    logic        wrt, pend, ovf_s, idx_s;
    ent_t        e, pe;
    logic [3:0]  tgt, disp, nrdy;
    if (reset) begin
      q.delete();
      m_stage = '0; m_rdy = '0; m_patt = '0; m_ovf = 0; m_idx = 0;
      for (int i = 0; i < NM; i++) begin m_data[i] = '0; m_ctl[i] = '0; end
      return;
    end
    off   = daddr[31:2] - BASE[31:2];
    wrt   = (dwe != 4'h0);
    pend  = 0; ovf_s = 0; idx_s = 0; disp = '0; nrdy = m_rdy;
    pe    = '{bc: 1'b0, ctl: 16'h0, idx: 5'h0, dat: 64'h0};
    if (off == 30'd2 && dwe == 4'hF) begin
      if (q.size() == DEPTH) ovf_s = 1;
      else begin
        pend = 1;
        pe = '{bc: dwdata[31], ctl: dwdata[30:15], idx: dwdata[4:0], dat: m_stage};
      end
    end
    for (int b = 0; b < 4; b++) begin
      if (off == 30'd0 && dwe[b]) m_stage[8*b +: 8]    = dwdata[8*b +: 8];
      if (off == 30'd1 && dwe[b]) m_stage[32+8*b +: 8] = dwdata[8*b +: 8];
    end
    if (q.size() > 0) begin
      e   = q[0];
      tgt = e.bc ? 4'hF : ((e.idx < NM) ? 4'(1 << e.idx) : 4'h0);
      if ((tgt & m_rdy) == 4'h0) begin
        void'(q.pop_front());
        idx_s = !e.bc && (e.idx >= NM);
        for (int i = 0; i < NM; i++) begin
          if (tgt[i]) begin
            m_data[i] = e.dat;
            m_ctl[i]  = e.ctl;
            nrdy[i]   = (e.ctl[15:14] != 2'b00);
          end
        end
        disp = tgt;
      end
    end
    for (int i = 0; i < NM; i++) if (!disp[i] && data_accepted[i]) nrdy[i] = 0;
    if (pend) q.push_back(pe);
    m_patt = (m_patt & ~((off == 30'd4 && wrt) ? dwdata[3:0] : 4'h0)) | pattern_accepted;
    if (off == 30'd5 && wrt) begin
      if (dwdata[2]) m_ovf = 0;
      if (dwdata[3]) m_idx = 0;
    end
    m_ovf = m_ovf | ovf_s;
    m_idx = m_idx | idx_s;
    m_rdy = nrdy;
  endtask

  task automatic idle_inputs();
    daddr = '0; dwdata = '0; dwe = '0;
    data_accepted = '0; pattern_accepted = '0;
  endtask

  // One clock: check read data before the edge, advance the model, check outputs after.
  task automatic step();
    #1;
    check("drdata", 64'(drdata), 64'(model_rd(daddr, dwe)));
    model_step();
    @(posedge clk);
    #1;
    idle_inputs();
    check("data_ready", 64'(data_ready), 64'(m_rdy));
    for (int i = 0; i < NM; i++) begin
      check($sformatf("pmp_data%0d", i), pmp_data[64*i +: 64], m_data[i]);
      check($sformatf("pmp_control%0d", i), 64'(pmp_control[16*i +: 16]), 64'(m_ctl[i]));
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    daddr = a; dwdata = d; dwe = be;
    step();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    daddr = a; dwe = 4'h0;
    #1;
    v = drdata;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, d, a;
    logic [3:0]  be;
    int          r;

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    rd(BASE + 32'h14, v); check("status_after_reset", 64'(v), 64'h1);
    rd(BASE + 32'h0C, v); check("busy_after_reset", 64'(v), 64'h0);

    // single-module command and minimum latency
    wr(BASE + 32'h00, 32'h1122_3344, 4'hF);
    wr(BASE + 32'h04, 32'h5566_7788, 4'hF);
    wr(BASE + 32'h08, 32'h4000_8001, 4'hF);
    check("ready_one_edge_after_cmd", 64'(data_ready), 64'h0);
    step();
    check("m1_data", pmp_data[127:64], 64'h5566_7788_1122_3344);
    check("m1_ctl", 64'(pmp_control[31:16]), 64'h8001);
    check("m1_ready", 64'(data_ready), 64'h2);
    data_accepted = 4'b0010;
    step();
    check("m1_accept", 64'(data_ready), 64'h0);

    // broadcast
    wr(BASE + 32'h08, 32'hC000_0000, 4'hF);
    step();
    check("bcast_ready", 64'(data_ready), 64'hF);
    rd(BASE + 32'h0C, v); check("bcast_busy", 64'(v), 64'hF);
    data_accepted = 4'hF;
    step();

    // overflow with module 0 held busy, then in-order drain
    wr(BASE + 32'h00, 32'hAAAA_0000, 4'hF);
    wr(BASE + 32'h08, 32'h4000_8000, 4'hF);
    step();
    check("m0_busy", 64'(data_ready), 64'h1);
    for (int k = 0; k < 5; k++) begin
      wr(BASE + 32'h00, 32'(100 + k), 4'hF);
      wr(BASE + 32'h08, 32'h4000_8000, 4'hF);
    end
    rd(BASE + 32'h14, v); check("status_full_ovf", 64'(v), 64'h406);
    for (int k = 0; k < 4; k++) begin
      data_accepted = 4'b0001;
      step();
      step();
      check("drain_order", pmp_data[63:0], {32'h5566_7788, 32'(100 + k)});
      check("drain_ready", 64'(data_ready), 64'h1);
    end
    data_accepted = 4'b0001;
    step();
    wr(BASE + 32'h14, 32'h4, 4'hF);
    rd(BASE + 32'h14, v); check("ovf_cleared", 64'(v), 64'h1);

    // out-of-range index
    wr(BASE + 32'h08, 32'h4000_8007, 4'hF);
    step();
    check("idx_no_ready", 64'(data_ready), 64'h0);
    rd(BASE + 32'h14, v); check("status_idx", 64'(v), 64'h9);
    wr(BASE + 32'h14, 32'h8, 4'hF);
    rd(BASE + 32'h14, v); check("idx_cleared", 64'(v), 64'h1);

    // PATT set wins over same-cycle clear
    pattern_accepted = 4'b0100;
    wr(BASE + 32'h10, 32'h4, 4'hF);
    rd(BASE + 32'h10, v); check("patt_set_wins", 64'(v), 64'h4);
    wr(BASE + 32'h10, 32'h4, 4'hF);
    rd(BASE + 32'h10, v); check("patt_cleared", 64'(v), 64'h0);

    // reset mid-handshake with queued entries
    wr(BASE + 32'h08, 32'h4000_8000, 4'hF);
    wr(BASE + 32'h08, 32'h4000_8001, 4'hF);
    step();
    check("two_ready", 64'(data_ready), 64'h3);
    wr(BASE + 32'h08, 32'h4000_8000, 4'hF);
    wr(BASE + 32'h08, 32'h4000_8000, 4'hF);
    rd(BASE + 32'h14, v); check("status_count2", 64'(v), 64'h200);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("ready_after_reset", 64'(data_ready), 64'h0);
    rd(BASE + 32'h14, v); check("status_after_mid_reset", 64'(v), 64'h1);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      r  = $urandom_range(0, 9);
      d  = $urandom;
      be = 4'hF;
      if ($urandom_range(0, 3) == 0) be = 4'($urandom_range(1, 15));
      a  = BASE | 32'($urandom_range(0, 3));
      case (r)
        0: a = a + 32'h00;
        1: a = a + 32'h04;
        2, 3: begin
          a = a + 32'h08;
          if ($urandom_range(0, 5) != 0) be = 4'hF;
          d[31]  = ($urandom_range(0, 7) == 0);
          d[4:0] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(4, 31))
                                                 : 5'($urandom_range(0, 3));
        end
        4: a = a + 32'h10;
        5: a = a + 32'h14;
        6: a = ($urandom_range(0, 1) == 0) ? BASE + 32'h18 : $urandom;
        default: begin
          a  = BASE + 32'(4 * $urandom_range(0, 7));
          be = 4'h0;
        end
      endcase
      daddr  = a;
      dwdata = d;
      dwe    = be;
      data_accepted    = 4'($urandom) & 4'($urandom);
      pattern_accepted = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      reset  = ($urandom_range(0, 199) == 0);
      step();
      reset  = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pmp_mmio_ctrl.md
PMP_MMIO_CTRL -- requirements
Module: pmp_mmio_ctrl

Interface
REQ-001 The block SHALL take parameter NUM_MODULES, default 4, giving the number of pattern-matching modules served (legal range 1..32).
REQ-002 The block SHALL take parameter BASE_ADDR, default 32'h0040_0000, giving the word-aligned base of the register window.
REQ-003 The block SHALL take parameter FIFO_DEPTH, default 4, giving the command FIFO depth (power of two, >=2).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 daddr  in  32  CPU byte address; word select is daddr[31:2].
REQ-008 dwdata  in  32  CPU write data.
REQ-009 dwe  in  4  per-byte write enables; 0 means read.
REQ-010 drdata  out  32  CPU read data, combinational.
REQ-011 pmp_data  out  64*NUM_MODULES  per-module 64-bit data, module i at [64i+63:64i].
REQ-012 pmp_control  out  16*NUM_MODULES  per-module control, module i at [16i+15:16i].
REQ-013 data_ready  out  NUM_MODULES  per-module command-valid.
REQ-014 data_accepted  in  NUM_MODULES  per-module one-cycle accept pulse.
REQ-015 pattern_accepted  in  NUM_MODULES  per-module one-cycle match pulse.

Function
REQ-016 Register map (offsets from BASE_ADDR) SHALL be: 0x00 DATA_LO (W), 0x04 DATA_HI (W), 0x08 CMD (W), 0x0C BUSY (R), 0x10 PATT (R/W1C), 0x14 STATUS (R/W1C).
REQ-017 DATA_LO/DATA_HI writes SHALL update only bytes whose dwe bit is set, forming a 64-bit staging buffer {HI,LO}.
REQ-018 A CMD write SHALL be accepted only with dwe==4'b1111; other dwe values at 0x08 SHALL be ignored.
REQ-019 An accepted CMD write SHALL push {dwdata[31] broadcast, dwdata[30:15] control, dwdata[4:0] index, staging buffer} into the FIFO at that edge.
REQ-020 A CMD write while the FIFO is full (evaluated before any same-cycle pop) SHALL be dropped and set STATUS.OVF.
REQ-021 The FIFO head SHALL be dispatched at an edge when the FIFO is non-empty and every target module has data_ready==0; target = all modules if broadcast, else module index.
REQ-022 Dispatch SHALL load pmp_data and pmp_control of each target and pop the head at the same edge.
REQ-023 Dispatch SHALL set data_ready for each target unless control[15:14]==2'b00 (NOP), in which case data_ready stays 0.
REQ-024 A non-broadcast entry with index >= NUM_MODULES SHALL be popped without driving any module and SHALL set STATUS.IDX.
REQ-025 data_ready[i] SHALL clear at the edge after data_accepted[i]==1; data_accepted[i] while data_ready[i]==0 SHALL be ignored.
REQ-026 Minimum latency SHALL be: CMD write at edge N into empty FIFO, idle target -> data_ready high after edge N+1.
REQ-027 PATT[i] SHALL set on pattern_accepted[i] and clear on a PATT write with dwdata[i]==1 and dwe!=0; same-cycle set and clear SHALL leave the bit set.
REQ-028 BUSY read SHALL return data_ready zero-extended to 32 bits.
REQ-029 STATUS SHALL read {fill count in [15:8], 4'b0, IDX[3], OVF[2], full[1], empty[0]}; write-1 to bits 3/2 with dwe!=0 SHALL clear them, set wins on collision.
REQ-030 drdata SHALL be the addressed register when dwe==0 and address hits 0x0C/0x10/0x14, else 0.
REQ-031 Addresses outside the window SHALL have no effect.

Reset
REQ-032 While reset is high at an edge, staging buffer, FIFO (empty, count 0), pmp_data, pmp_control, data_ready, PATT, OVF, IDX SHALL all clear to 0; writes and dispatch in that cycle SHALL be discarded.
REQ-033 Reset mid-handshake SHALL drop data_ready immediately after that edge with no later accept required.

Verification
REQ-034 Write DATA_LO=0x11223344, DATA_HI=0x55667788, CMD=0x4000_8001 -> after next edge pmp_data[127:64]=0x5566778811223344, pmp_control[31:16]=0x8001, data_ready=4'b0010; data_accepted[1] pulse -> data_ready=0.
REQ-035 Broadcast CMD=0xC000_0000 with all idle -> all four modules loaded, data_ready=4'b1111; BUSY reads 0xF.
REQ-036 Hold module 0 busy, issue 5 CMDs to index 0 -> 4 queued, STATUS.full=1, 5th dropped, OVF=1; accepts drain FIFO in order.
REQ-037 CMD index 7 with NUM_MODULES=4 -> no output change, STATUS.IDX=1; write 0x8 to STATUS -> IDX=0.
REQ-038 pattern_accepted[2] pulse same cycle as PATT write 0x4 -> PATT reads 0x4; next PATT write 0x4 -> reads 0.
REQ-039 Assert reset while data_ready=4'b0011 and FIFO count 2 -> next cycle data_ready=0, STATUS=0x0000_0001.
